// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants for the programmable LFSR random source
//
// Contents:
//   MODE_FIB / MODE_GAL      encoding of the mode input
//   TAPS_W4 .. TAPS_W32      maximal-length tap masks for common widths
//   ST_EMPTY/HELD/STALLED    output collector FSM state codes

package lfsr_pkg;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // Bit i of a mask set means state bit i participates in the feedback.
    // These correspond to the usual primitive polynomials (x^n + ... + 1).
    localparam logic [3:0]  TAPS_W4  = 4'b1100;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    // EMPTY: no word held. HELD: word held, collecting the next one.
    // STALLED: word held and the next one is one bit from done, so the
    // LFSR is frozen until the consumer takes the held word.
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_HELD    = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next-state function of the LFSR
//
// Ports:
//   state      in   WIDTH  current LFSR state
//   taps       in   WIDTH  feedback tap mask
//   mode       in   1      MODE_FIB or MODE_GAL
//   next_state out  WIDTH  state after one step
//   is_zero    out  1      next_state is all zeros (lock-up would follow)

module lfsr_next #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    output logic [WIDTH-1:0] next_state,
    output logic             is_zero
);
    import lfsr_pkg::*;

    logic             fib_fb;
    logic [WIDTH-1:0] gal_mask;

    always_comb begin
        // Fibonacci: parity of the tapped bits enters at the LSB.
        fib_fb   = ^(state & taps);
        // Galois: the bit shifted out of the MSB toggles every tapped bit.
        gal_mask = {WIDTH{state[WIDTH-1]}} & taps;

        if (mode == MODE_GAL) begin
            next_state = (state << 1) ^ gal_mask;
        end else begin
            next_state = {state[WIDTH-2:0], fib_fb};
        end

        is_zero = (next_state == '0);
    end

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - programmable LFSR with word packer and valid/ready output
//
// Parameters:
//   WIDTH         LFSR length (3..32)
//   OUT_W         bits per output word (1..WIDTH)
//   DEFAULT_TAPS  tap mask after reset and when a zero mask is loaded
//   SEED_DEF      state after reset and after lock-up recovery (non-zero)
//
// Ports:
//   Cp          in   1      clock, rising edge
//   R_n         in   1      asynchronous active-low reset
//   en          in   1      advance one step per cycle
//   mode        in   1      0 Fibonacci, 1 Galois, sampled every step
//   taps_we     in   1      load taps_in (zero selects DEFAULT_TAPS)
//   taps_in     in   WIDTH  new tap mask
//   seed_we     in   1      load seed_in (zero selects SEED_DEF + lockup)
//   seed_in     in   WIDTH  new seed
//   state       out  WIDTH  current LFSR state
//   bit_out     out  1      state MSB
//   word        out  OUT_W  packed output word, first bit in the MSB
//   word_valid  out  1      word holds an unread value
//   word_ready  in   1      consumer takes word this cycle
//   lockup      out  1      sticky zero-state recovery flag

module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEF     = WIDTH'(1)
) (
    input  logic             Cp,
    input  logic             R_n,
    input  logic             en,
    input  logic             mode,
    input  logic             taps_we,
    input  logic [WIDTH-1:0] taps_in,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic [OUT_W-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             lockup
);

    // With OUT_W == 1 there is no partial word to hold; keep one dummy bit
    // so the declarations stay legal and truncate it away when packing.
    localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int               SH_W     = (OUT_W > 1) ? OUT_W - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] taps_q,   taps_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [SH_W-1:0]  shreg_q,  shreg_d;
    logic [OUT_W-1:0] word_q,   word_d;
    logic [1:0]       fsm_q,    fsm_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] step_next;
    logic             step_zero;
    logic             held;
    logic             last_bit;
    logic             stall;
    logic             step;
    logic             complete;
    logic             valid_d;

    lfsr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .state      (state_q),
        .taps       (taps_q),
        .mode       (mode),
        .next_state (step_next),
        .is_zero    (step_zero)
    );

    always_comb begin
        held     = (fsm_q != ST_EMPTY);
        last_bit = (cnt_q == CNT_LAST);
        // Completing a word while one is still unread would overwrite it,
        // so the whole generator freezes on the final bit instead.
        stall    = held & ~word_ready & last_bit;
        step     = en & ~seed_we & ~stall;
        complete = step & last_bit;

        state_d  = state_q;
        taps_d   = taps_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        word_d   = word_q;
        lockup_d = lockup_q;

        // Registered mask: a step in the load cycle still uses the old taps.
        if (taps_we) begin
            taps_d = (taps_in == '0) ? DEFAULT_TAPS : taps_in;
        end

        if (seed_we) begin
            cnt_d   = '0;
            shreg_d = '0;
            if (seed_in == '0) begin
                state_d  = SEED_DEF;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_in;
                lockup_d = 1'b0;
            end
        end else if (step) begin
            shreg_d = SH_W'({shreg_q, state_q[WIDTH-1]});
            cnt_d   = complete ? '0 : cnt_q + 1'b1;
            if (step_zero) begin
                state_d  = SEED_DEF;
                lockup_d = 1'b1;
            end else begin
                state_d  = step_next;
            end
        end

        if (complete) begin
            word_d = OUT_W'({shreg_q, state_q[WIDTH-1]});
        end

        // A word completing in the same cycle the old one is taken keeps
        // valid high with the new contents.
        valid_d = complete | (held & ~word_ready);

        if (!valid_d) begin
            fsm_d = ST_EMPTY;
        end else if (stall) begin
            // seed_we clears cnt, so a stall that coincides with a seed
            // load is already unblocked next cycle.
            fsm_d = seed_we ? ST_HELD : ST_STALLED;
        end else begin
            fsm_d = ST_HELD;
        end
    end

    always_ff @(posedge Cp or negedge R_n) begin
        if (!R_n) begin
            state_q  <= SEED_DEF;
            taps_q   <= DEFAULT_TAPS;
            cnt_q    <= '0;
            shreg_q  <= '0;
            word_q   <= '0;
            fsm_q    <= ST_EMPTY;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            fsm_q    <= fsm_d;
            lockup_q <= lockup_d;
        end
    end

    assign state      = state_q;
    assign bit_out    = state_q[WIDTH-1];
    assign word       = word_q;
    assign word_valid = held;
    assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - scoreboard bench for lfsr_rng (WIDTH=4, OUT_W=4)

module tb_lfsr_rng;

    localparam logic [3:0] DEF_TAPS = 4'b1100;
    localparam logic [3:0] SEED     = 4'b0001;
    localparam int         OW       = 4;

    logic       Cp = 1'b0;
    logic       R_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       taps_we = 1'b0;
    logic       seed_we = 1'b0;
    logic       word_ready = 1'b0;
    logic [3:0] taps_in = 4'd0;
    logic [3:0] seed_in = 4'd0;
    logic [3:0] state;
    logic       bit_out;
    logic [3:0] word;
    logic       word_valid;
    logic       lockup;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    logic [3:0] m_state;
    logic [3:0] m_taps;
    bit         m_lock;
    bit         m_valid;
    bit         m_bits[$];

    logic [3:0] fib_exp [4]  = '{4'h2, 4'h4, 4'h9, 4'h3};
    logic [3:0] gal_exp [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    bit         r_en, r_mode, r_twe, r_swe, r_rdy;
    logic [3:0] r_tin, r_sin;

    lfsr_rng #(
        .WIDTH        (4),
        .OUT_W        (OW),
        .DEFAULT_TAPS (DEF_TAPS),
        .SEED_DEF     (SEED)
    ) dut (
        .Cp         (Cp),
        .R_n        (R_n),
        .en         (en),
        .mode       (mode),
        .taps_we    (taps_we),
        .taps_in    (taps_in),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .state      (state),
        .bit_out    (bit_out),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .lockup     (lockup)
    );

    always #5 Cp = ~Cp;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step written as polynomial arithmetic on integers.
    function automatic logic [3:0] ref_next(logic [3:0] s, logic [3:0] t, bit gal);
        int v;
        int ones;
        v = int'(s) * 2;
        if (gal) begin
            if (v >= 16) v = (v - 16) ^ int'(t);
        end else begin
            ones = 0;
            for (int i = 0; i < 4; i++) if (s[i] && t[i]) ones++;
            v = (v % 16) + (ones % 2);
        end
        return v[3:0];
    endfunction

    function automatic void model_reset();
        m_state = SEED;
        m_taps  = DEF_TAPS;
        m_lock  = 1'b0;
        m_valid = 1'b0;
        m_bits.delete();
        exp_q.delete();
    endfunction

    function automatic void model_clock(bit e, bit md, bit twe, logic [3:0] tin,
                                        bit swe, logic [3:0] sin, bit rdy);
        bit         stall;
        logic [3:0] nxt;
        logic [3:0] w;
        stall = m_valid && !rdy && (m_bits.size() == OW - 1);
        if (m_valid && rdy) m_valid = 1'b0;
        if (swe) begin
            m_bits.delete();
            if (sin == 4'd0) begin m_state = SEED; m_lock = 1'b1; end
            else begin m_state = sin; m_lock = 1'b0; end
        end else if (e && !stall) begin
            m_bits.push_back(m_state[3]);
            nxt = ref_next(m_state, m_taps, md);
            if (nxt == 4'd0) begin m_state = SEED; m_lock = 1'b1; end
            else m_state = nxt;
            if (m_bits.size() == OW) begin
                w = 4'd0;
                foreach (m_bits[i]) w = {w[2:0], m_bits[i]};
                exp_q.push_back(w);
                m_bits.delete();
                m_valid = 1'b1;
            end
        end
        if (twe) m_taps = (tin == 4'd0) ? DEF_TAPS : tin;
    endfunction

    task automatic check_all();
        chk("state", state, m_state);
        chk("lockup", lockup, m_lock);
        chk("word_valid", word_valid, m_valid);
        chk("bit_out", bit_out, m_state[3]);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(bit e, bit md, bit twe, logic [3:0] tin,
                        bit swe, logic [3:0] sin, bit rdy);
        #1;
        en = e; mode = md; taps_we = twe; taps_in = tin;
        seed_we = swe; seed_in = sin; word_ready = rdy;
        model_clock(e, md, twe, tin, swe, sin, rdy);
        @(negedge Cp);
        check_all();
    endtask

    // Reset asserted between edges; outputs must change before any Cp edge.
    task automatic async_reset(string tag);
        #1;
        en = 1'b0; seed_we = 1'b0; taps_we = 1'b0; word_ready = 1'b0;
        #2;
        R_n = 1'b0;
        #1;
        chk({tag, "_rst_state"}, state, SEED);
        chk({tag, "_rst_valid"}, word_valid, 1'b0);
        chk({tag, "_rst_word"}, word, 4'd0);
        chk({tag, "_rst_lockup"}, lockup, 1'b0);
        chk({tag, "_rst_bit_out"}, bit_out, SEED[3]);
        model_reset();
        @(negedge Cp);
        #1;
        R_n = 1'b1;
        @(negedge Cp);
        check_all();
    endtask

    // Monitor: pops the scoreboard on every accepted word.
    initial begin
        forever begin
            @(negedge Cp);
            #2;
            if (R_n && word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word_unexpected: got %0h expected none", word);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", word, mon_exp);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(posedge Cp);
        #2;
        chk("init_state", state, SEED);
        chk("init_valid", word_valid, 1'b0);
        chk("init_word", word, 4'd0);
        chk("init_lockup", lockup, 1'b0);
        @(negedge Cp);
        #1;
        R_n = 1'b1;
        @(negedge Cp);
        check_all();

        // Fibonacci with default taps 1100 from seed 0001.
        tick(0, 0, 0, 4'd0, 1, 4'b0001, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
            chk("fib_seq", state, fib_exp[i]);
        end
        chk("first_word_valid", word_valid, 1'b1);
        chk("first_word", word, 4'b0001);
        for (int i = 0; i < 11; i++) tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
        chk("fib_period", state, 4'b0001);

        // Galois, taps 0011 loaded together with the seed.
        tick(0, 1, 1, 4'b0011, 1, 4'b0001, 1);
        for (int i = 0; i < 15; i++) begin
            tick(1, 1, 0, 4'd0, 0, 4'd0, 1);
            chk("gal_seq", state, gal_exp[i]);
        end

        // Zero seed recovery and clearing by a non-zero seed.
        tick(0, 0, 0, 4'd0, 1, 4'd0, 1);
        chk("zero_seed_state", state, SEED);
        chk("zero_seed_lockup", lockup, 1'b1);
        tick(0, 0, 0, 4'd0, 1, 4'b0101, 1);
        chk("seed_clears_lockup", lockup, 1'b0);
        chk("seed_0101", state, 4'b0101);

        // Zero next state reached by a step.
        tick(0, 0, 1, 4'b0111, 1, 4'b1000, 1);
        tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
        chk("step_zero_state", state, SEED);
        chk("step_zero_lockup", lockup, 1'b1);

        // Zero tap mask falls back to the default mask.
        tick(0, 0, 1, 4'd0, 1, 4'b0001, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
            chk("default_taps_seq", state, fib_exp[i]);
        end

        // Ready held low across two words, a single ready pulse, then reset
        // while stalled.
        tick(0, 0, 0, 4'd0, 1, 4'b0001, 1);
        for (int i = 0; i < 12; i++) tick(1, 0, 0, 4'd0, 0, 4'd0, 0);
        tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
        chk("valid_continuous", word_valid, 1'b1);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 4'd0, 0, 4'd0, 0);
        async_reset("stall");

        // Reset in the middle of a word.
        tick(0, 0, 0, 4'd0, 1, 4'b0101, 1);
        tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
        tick(1, 0, 0, 4'd0, 0, 4'd0, 1);
        async_reset("midword");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            r_en   = ($urandom_range(0, 9) < 8);
            r_mode = $urandom_range(0, 1);
            r_twe  = ($urandom_range(0, 19) == 0);
            r_tin  = $urandom_range(0, 15);
            r_swe  = ($urandom_range(0, 24) == 0);
            r_sin  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r_rdy  = ($urandom_range(0, 9) < 6);
            tick(r_en, r_mode, r_twe, r_tin, r_swe, r_sin, r_rdy);
        end

        for (int i = 0; i < 6; i++) tick(0, 0, 0, 4'd0, 0, 4'd0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised pseudo-random source: a WIDTH-bit LFSR with run-time programmable tap mask, Fibonacci/Galois mode, seed load, and all-zero lock-up recovery. It also packs the serial output into OUT_W-bit words behind a valid/ready handshake. It supersedes the fixed 4-bit, 3-tap generator and feeds test-pattern and dither consumers elsewhere in the design.

## Interface
- WIDTH, 16, LFSR length, 3..32
- OUT_W, 8, bits per output word, 1..WIDTH
- DEFAULT_TAPS, 16'hB400, tap mask after reset and on rejected tap load
- SEED_DEF, 1, state after reset and on lock-up recovery; must be non-zero
- Cp  in  1  clock, rising edge
- R_n  in  1  asynchronous active-low reset
- en  in  1  advance the LFSR one step per cycle when high
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every step
- taps_we  in  1  load taps_in into the tap register
- taps_in  in  WIDTH  new tap mask
- seed_we  in  1  load seed_in into the state register
- seed_in  in  WIDTH  new seed
- state  out  WIDTH  current LFSR state
- bit_out  out  1  state[WIDTH-1], combinational from state
- word  out  OUT_W  packed output word
- word_valid  out  1  word holds an unread value
- word_ready  in  1  consumer accepts word this cycle
- lockup  out  1  sticky; set on zero-state recovery

## Operation
- Step enable: step = en & ~seed_we & ~stall, where stall = word_valid & ~word_ready & (cnt == OUT_W-1).
- Fibonacci step: fb = ^(state & taps); next = {state[WIDTH-2:0], fb}.
- Galois step: m = state[WIDTH-1]; next = (state << 1) ^ ({WIDTH{m}} & taps).
- Zero guard: if the computed next state or seed_in is zero, state loads SEED_DEF and lockup is set. Only a seed_we with non-zero seed_in clears lockup.
- Tap load: taps_we with taps_in == 0 loads DEFAULT_TAPS. New taps take effect on the first step after the load cycle. taps_we is independent of step.
- Collector: shreg (OUT_W-1 bits) and cnt (0..OUT_W-1). Each step shifts bit_out (pre-step value) into the LSB of shreg and increments cnt.
- When a step occurs with cnt == OUT_W-1: word <= {shreg, bit_out}, word_valid <= 1, cnt <= 0.
- word_valid clears on word_ready unless a new word completes in the same cycle. In that case word takes the new value and valid stays 1.
- seed_we has priority over step. It clears cnt and shreg but leaves word and word_valid untouched.
- FSM on collector/output: EMPTY (word_valid = 0), HELD (valid, collecting next word), STALLED (valid, next word complete, LFSR frozen).
  - EMPTY → HELD on word completion.
  - HELD → EMPTY on ready with no completion.
  - HELD → STALLED when cnt == OUT_W-1 and ready is low.
  - STALLED → HELD on ready; completion is allowed in the same cycle.

## Timing
- Reset (R_n low, asynchronous) values:
  - state = SEED_DEF, taps = DEFAULT_TAPS
  - cnt = 0, shreg = 0, word = 0
  - word_valid = 0, lockup = 0
  - bit_out = SEED_DEF[WIDTH-1]
- Reset deassertion is used synchronously; the first step can occur on the first rising edge with R_n high.
- All state updates happen on the rising edge of Cp. state, word and word_valid are registered.
- Latency: a seed appears on state 1 cycle after seed_we. The first word is valid OUT_W step-cycles after seed load.
- Throughput: one bit per cycle and one word per OUT_W cycles while word_ready stays high.
- Reset asserted mid-word discards the partial word and any pending word.

## Structure
- Shared package lfsr_pkg holds:
  - Mode encoding constants MODE_FIB and MODE_GAL.
  - Recommended maximal-length tap masks for WIDTH 4, 8, 16 and 32.
- Sub-module lfsr_next: combinational next-state function (state, taps, mode → next, is_zero).
- The top level holds the registers, collector, FSM and zero guard.

## Test plan
- WIDTH=4, OUT_W=4, Fibonacci, taps 4'b1100, seed 4'b0001, en held high:
  - state goes 0010, 0100, 1001, 0011.
  - First word = 4'b0001.
  - state returns to 0001 after exactly 15 steps.
- WIDTH=4, Galois, taps 4'b0011, seed 0001:
  - state goes 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110, 1111, 1101, 1001, 0001 (period 15).
- seed_in = 0 with seed_we:
  - state = SEED_DEF and lockup = 1 next cycle.
  - A subsequent seed_we with seed_in = 4'b0101 clears lockup.
- taps_in = 0:
  - taps reads back DEFAULT_TAPS.
  - Sequence from seed 0001 matches the reset-default run.
- Hold word_ready low across two words:
  - state freezes with cnt = OUT_W-1; no word is lost or overwritten.
  - A one-cycle ready pulse yields the next word immediately, with word_valid continuous.
- Assert R_n low mid-word and mid-stall:
  - All outputs return to their reset values asynchronously, before the next Cp edge.
